// File: rtl/timer_period_arbiter.sv
// Two-port round-robin arbiter that loads a requested period into a timer and restarts it.
// Optional define TIMER_ARB_TICK_COUNT_EN adds tick_count_o, the expiries counted since the last load.
module timer_period_arbiter #(
  parameter int WIDTH         = 32,
  parameter int MIN_COUNT     = 5,
  parameter int DEFAULT_COUNT = 100000000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] a_period_i,
  input  logic [WIDTH-1:0] b_period_i,
  input  logic             a_req_i,
  input  logic             b_req_i,
  output logic             a_ack_o,
  output logic             b_ack_o,
  output logic             a_clamped_o,
  output logic             b_clamped_o,
  output logic [WIDTH-1:0] max_count_o,
  output logic             max_count_wr_o,
  output logic             timer_rst_o,
  input  logic             count_reached_i,
  output logic             busy_o,
`ifdef TIMER_ARB_TICK_COUNT_EN
  output logic [31:0]      tick_count_o,
`endif
  output logic [WIDTH-1:0] active_period_o
);

  localparam logic [WIDTH-1:0] MinVal = WIDTH'(MIN_COUNT);
  localparam logic [WIDTH-1:0] DefVal = WIDTH'(DEFAULT_COUNT);

  typedef enum logic [2:0] {IDLE, LOAD, RESTART, SETTLE0, SETTLE1, ACK} state_t;

  state_t           state_q, state_d;
  logic             grant, grant_b;
  logic             rr_b_q;    // 1: B wins the next contested grant
  logic             gnt_b_q;   // port owning the transaction in flight
  logic             clamped_q;
  logic [WIDTH-1:0] req_period;
  logic [WIDTH-1:0] period_q, active_q;

  assign req_period = grant_b ? b_period_i : a_period_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; combinational blocks use blocking assignments.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d         = state_q;
    grant           = 1'b0;
    grant_b         = 1'b0;
    a_ack_o         = 1'b0;
    b_ack_o         = 1'b0;
    a_clamped_o     = 1'b0;
    b_clamped_o     = 1'b0;
    max_count_wr_o  = 1'b0;
    timer_rst_o     = rst_i;
    busy_o          = 1'b0;
    max_count_o     = rst_i ? DefVal : period_q;
    active_period_o = rst_i ? DefVal : active_q;
    if (!rst_i) begin
      busy_o = (state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          if (a_req_i || b_req_i) begin
            grant   = 1'b1;
            grant_b = b_req_i && (!a_req_i || rr_b_q);
            state_d = LOAD;
          end
        end
        LOAD: begin
          max_count_wr_o = 1'b1;
          state_d        = RESTART;
        end
        RESTART: begin
          timer_rst_o = 1'b1;
          state_d     = SETTLE0;
        end
        SETTLE0: state_d = SETTLE1;
        SETTLE1: state_d = ACK;
        ACK: begin
          a_ack_o     = !gnt_b_q;
          b_ack_o     = gnt_b_q;
          a_clamped_o = !gnt_b_q && clamped_q;
          b_clamped_o = gnt_b_q && clamped_q;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Capture happens on the grant edge, so later period_i changes cannot leak in.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_b_q    <= 1'b0;
      gnt_b_q   <= 1'b0;
      clamped_q <= 1'b0;
      period_q  <= DefVal;
      active_q  <= DefVal;
    end else begin
      if (grant) begin
        gnt_b_q   <= grant_b;
        rr_b_q    <= !grant_b;
        clamped_q <= (req_period < MinVal);
        period_q  <= (req_period < MinVal) ? MinVal : req_period;
      end
      if (state_q == SETTLE1) active_q <= period_q;
    end
  end

`ifdef TIMER_ARB_TICK_COUNT_EN
  logic [31:0] tick_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)                                   tick_q <= '0;
    else if (state_q == LOAD)                    tick_q <= '0;
    else if (count_reached_i && state_q == IDLE) tick_q <= tick_q + 32'd1;
  end

  assign tick_count_o = rst_i ? 32'd0 : tick_q;
`else
  logic unused_count_reached;
  assign unused_count_reached = count_reached_i;
`endif

endmodule

// File: tb/tb_timer_period_arbiter.sv
// Directed self-checking bench for timer_period_arbiter; define TIMER_ARB_TICK_COUNT_EN to cover the tick counter.
module tb_timer_period_arbiter;

  localparam int WIDTH = 32;
  localparam int DEF   = 100000000;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [WIDTH-1:0] a_period_i, b_period_i;
  logic             a_req_i, b_req_i;
  logic             a_ack_o, b_ack_o, a_clamped_o, b_clamped_o;
  logic [WIDTH-1:0] max_count_o, active_period_o;
  logic             max_count_wr_o, timer_rst_o, count_reached_i, busy_o;
`ifdef TIMER_ARB_TICK_COUNT_EN
  logic [31:0]      tick_count_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  timer_period_arbiter #(.WIDTH(WIDTH), .MIN_COUNT(5), .DEFAULT_COUNT(DEF)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .a_period_i      (a_period_i),
    .b_period_i      (b_period_i),
    .a_req_i         (a_req_i),
    .b_req_i         (b_req_i),
    .a_ack_o         (a_ack_o),
    .b_ack_o         (b_ack_o),
    .a_clamped_o     (a_clamped_o),
    .b_clamped_o     (b_clamped_o),
    .max_count_o     (max_count_o),
    .max_count_wr_o  (max_count_wr_o),
    .timer_rst_o     (timer_rst_o),
    .count_reached_i (count_reached_i),
    .busy_o          (busy_o),
`ifdef TIMER_ARB_TICK_COUNT_EN
    .tick_count_o    (tick_count_o),
`endif
    .active_period_o (active_period_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  int ack_seen;

  initial begin
    rst_i = 1'b1; a_req_i = 1'b0; b_req_i = 1'b0;
    a_period_i = '0; b_period_i = '0; count_reached_i = 1'b0;
    step(2);
    check("rst_busy", busy_o, 0);
    check("rst_timer_rst", timer_rst_o, 1);
    check("rst_max_count", max_count_o, DEF);
    check("rst_active", active_period_o, DEF);
    check("rst_wr", max_count_wr_o, 0);
    check("rst_acks", {a_ack_o, b_ack_o, a_clamped_o, b_clamped_o}, 0);
`ifdef TIMER_ARB_TICK_COUNT_EN
    check("rst_tick", tick_count_o, 0);
`endif
    rst_i = 1'b0;
    step();
    check("post_rst_timer_rst", timer_rst_o, 0);

    // A alone, period 1000
    a_period_i = 1000; a_req_i = 1'b1;
    check("a_c0_busy", busy_o, 0);
    step();
    check("a_c1_wr", max_count_wr_o, 1);
    check("a_c1_max", max_count_o, 1000);
    check("a_c1_busy", busy_o, 1);
    step();
    check("a_c2_timer_rst", timer_rst_o, 1);
    check("a_c2_wr", max_count_wr_o, 0);
    step(2);
    check("a_c4_ack", a_ack_o, 0);
    step();
    check("a_c5_ack", a_ack_o, 1);
    check("a_c5_clamped", a_clamped_o, 0);
    check("a_c5_b_ack", b_ack_o, 0);
    check("a_c5_active", active_period_o, 1000);
    a_req_i = 1'b0;
    step();
    check("a_c6_ack", a_ack_o, 0);
    check("a_c6_busy", busy_o, 0);
    check("a_c6_max_hold", max_count_o, 1000);

    // B alone, period below minimum
    b_period_i = 3; b_req_i = 1'b1;
    step();
    check("b_c1_max", max_count_o, 5);
    check("b_c1_wr", max_count_wr_o, 1);
    step(4);
    check("b_c5_ack", b_ack_o, 1);
    check("b_c5_clamped", b_clamped_o, 1);
    check("b_c5_active", active_period_o, 5);
    b_req_i = 1'b0;
    step();

    // Reset in SETTLE0 aborts the load
    a_period_i = 42; a_req_i = 1'b1;
    step(3);
    rst_i = 1'b1;
    #1;
    check("abort_timer_rst", timer_rst_o, 1);
    check("abort_busy_in_rst", busy_o, 0);
    check("abort_active_in_rst", active_period_o, DEF);
    step();
    rst_i = 1'b0; a_req_i = 1'b0;
    ack_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (a_ack_o || b_ack_o) ack_seen++;
      step();
    end
    check("abort_no_ack", ack_seen, 0);
    check("abort_busy_after", busy_o, 0);
    check("abort_active_after", active_period_o, DEF);

    // First simultaneous pair after reset: A then B
    a_period_i = 300; b_period_i = 400; a_req_i = 1'b1; b_req_i = 1'b1;
    step();
    check("pair1_c1_max", max_count_o, 300);
    step(4);
    check("pair1_c5_a_ack", a_ack_o, 1);
    check("pair1_c5_b_ack", b_ack_o, 0);
    a_req_i = 1'b0;
    step();
    check("pair1_c6_busy", busy_o, 0);
    step();
    check("pair1_c7_wr", max_count_wr_o, 1);
    check("pair1_c7_max", max_count_o, 400);
    step(3);
    check("pair1_c10_b_ack", b_ack_o, 0);
    step();
    check("pair1_c11_b_ack", b_ack_o, 1);
    check("pair1_c11_active", active_period_o, 400);
    b_req_i = 1'b0;
    step();

    // Period changed right after grant is ignored
    a_period_i = 2000; a_req_i = 1'b1;
    step();
    a_period_i = 7777;
    check("late_c1_max", max_count_o, 2000);
    step(4);
    check("late_c5_ack", a_ack_o, 1);
    check("late_c5_active", active_period_o, 2000);
    a_req_i = 1'b0;
    step();

    // Second simultaneous pair: pointer now favours B
    a_period_i = 600; b_period_i = 700; a_req_i = 1'b1; b_req_i = 1'b1;
    step();
    check("pair2_c1_max", max_count_o, 700);
    step(4);
    check("pair2_c5_b_ack", b_ack_o, 1);
    check("pair2_c5_a_ack", a_ack_o, 0);
    b_req_i = 1'b0;
    step(2);
    check("pair2_c7_max", max_count_o, 600);
    step(4);
    check("pair2_c11_a_ack", a_ack_o, 1);

    // Request held past ack is a new request
    step();
    check("rereq_c6_busy", busy_o, 0);
    step();
    check("rereq_c7_wr", max_count_wr_o, 1);
    a_req_i = 1'b0;
    step(5);
    check("rereq_idle", busy_o, 0);

`ifdef TIMER_ARB_TICK_COUNT_EN
    for (int i = 0; i < 7; i++) begin
      count_reached_i = 1'b1;
      step();
      count_reached_i = 1'b0;
      step();
    end
    check("tick_seven", tick_count_o, 7);
    a_period_i = 50; a_req_i = 1'b1;
    step(2);
    check("tick_cleared", tick_count_o, 0);
    count_reached_i = 1'b1;
    step();
    count_reached_i = 1'b0;
    step(2);
    check("tick_busy_ignored", tick_count_o, 0);
    a_req_i = 1'b0;
    step();
    count_reached_i = 1'b1;
    step();
    count_reached_i = 1'b0;
    check("tick_idle_one", tick_count_o, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
